result_uart_tx: RTL and testbench
=================================

Name: result_uart_tx

Overview:
Output stage that consumes the processor's result byte stream and serializes it as 8N1 asynchronous serial.
- Each store to data address 0 is presented as a one-cycle `result_valid` strobe with the byte on `result_data`. The integration logic decodes that strobe from the same condition that updates the processor's `result` register.
- Bytes are buffered in a small FIFO, so bursts of stores are not lost while the transmitter is busy.
- The serial line drives a host terminal or test monitor.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8: FIFO entries; must be a power of two, 2..256.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- result_valid  input  1  one-cycle strobe: `result_data` holds a new byte.
- result_data  input  8  byte to transmit.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high.
- Reset values:
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FSM in IDLE; all counters 0.
  - Reset mid-frame aborts the frame: tx is 1 from the cycle after reset is sampled, and FIFO contents are discarded.
- FIFO:
  - Circular buffer with separate read and write pointers that wrap modulo FIFO_DEPTH.
  - Push: on a clock edge with result_valid=1, provided fifo_count<FIFO_DEPTH or a pop occurs on the same edge.
  - Dropped push: if the FIFO is full and no pop occurs on that edge, the byte is dropped and overflow is set to 1. overflow is cleared only by reset.
  - Push and pop on the same edge leave fifo_count unchanged; the pushed byte is stored correctly even when full.
  - Pop reads the oldest entry (first in, first out).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head into the 8-bit shift register, clear the bit timer, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift register bit 0 (LSB first). Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if fifo_count>0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Frame timing:
  - Exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
  - Back-to-back frames have no idle cycles between them.
- Latency: with the FSM in IDLE and the FIFO empty, let edge E be the edge that samples result_valid.
  - The byte is written at E.
  - IDLE pops at E+1.
  - tx goes low in the cycle following E+1.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - Width is ceil(log2(CLKS_PER_BIT)), minimum 1.
- busy = (state != IDLE) || (fifo_count != 0), registered consistently with the state.
- tx is driven from a register and is glitch-free.
- The FIFO continues to accept pushes in every state, including during STOP.
- result_data is ignored when result_valid=0.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset then idle: hold reset 3 cycles -> tx=1, busy=0, overflow=0, fifo_count=0; tx stays 1 for 100 cycles with no strobe.
2. Single byte: pulse result_valid with 8'hA5 -> tx goes low 2 cycles after the sampling edge. Sample tx every 4 cycles: 0,1,0,1,0,0,1,0,1,1. busy falls right after the stop bit; total frame 40 cycles.
3. Back-to-back: push 8'h01, 8'h02, 8'h03 on consecutive cycles -> three frames totalling 120 cycles with no idle gap. Receiver model decodes 01,02,03 in order; fifo_count peaks at 2.
4. Overflow: push 8'h10..8'h17 on 8 consecutive cycles:
   - first byte is popped into the shift register; next four fill the FIFO;
   - 8'h15..8'h17 are dropped; overflow=1;
   - decoded output is 10,11,12,13,14;
   - overflow stays 1 until reset.
5. Push/pop collision at full: fill the FIFO during a frame, then pulse result_valid on the exact edge STOP ends and pops -> the byte is accepted, fifo_count stays 4, overflow remains 0, and the byte appears last in the decoded order.
6. Reset mid-frame: assert reset during DATA bit 3 of 8'hFF with 2 bytes queued -> tx=1 the next cycle, fifo_count=0, busy=0. After deassert, a new push of 8'h3C transmits correctly.

Source files
------------

// File: rtl/result_uart_tx_if.sv
// Result byte stream in, 8N1 serial line and FIFO status out.
// The master modport belongs to whatever produces result bytes.
interface result_uart_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          result_valid;
  logic [7:0]    result_data;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  modport master (
    output result_valid, result_data,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  result_valid, result_data,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/result_uart_tx.sv
// Buffers result bytes in a small FIFO and serializes them as 8N1, LSB first.
// Frames run back to back while the FIFO has data; tx idles high.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input logic             clk,
  input logic             reset,
  result_uart_tx_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [TW-1:0] r_bitTimer;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          r_overflow;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [7:0]    r_mem [FIFO_DEPTH];

  state_t        w_nextState;
  logic [TW-1:0] w_nextTimer;
  logic [2:0]    w_nextBitIdx;
  logic [7:0]    w_nextShift;
  logic          w_nextTx;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_bitDone;
  logic [7:0]    w_head;
  logic [CW-1:0] w_nextCount;

  assign w_head    = r_mem[r_rdPtr];
  assign w_bitDone = (r_bitTimer == TW'(CLKS_PER_BIT - 1));

  // A pop frees a slot on the same edge, so a full FIFO still accepts then.
  assign w_push      = bus.result_valid && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_drop      = bus.result_valid && !w_push;
  assign w_nextCount = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

  always_comb begin
    w_nextState  = r_state;
    w_nextTimer  = r_bitTimer + 1'b1;
    w_nextBitIdx = r_bitIdx;
    w_nextShift  = r_shift;
    w_nextTx     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextTimer = '0;
        w_nextTx    = 1'b1;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_nextShift = w_head;
          w_nextState = START;
          w_nextTx    = 1'b0;
        end
      end
      START: begin
        if (w_bitDone) begin
          w_nextTimer  = '0;
          w_nextBitIdx = 3'd0;
          w_nextState  = DATA;
          w_nextTx     = r_shift[0];
        end
      end
      DATA: begin
        if (w_bitDone) begin
          w_nextTimer = '0;
          if (r_bitIdx == 3'd7) begin
            w_nextState = STOP;
            w_nextTx    = 1'b1;
          end else begin
            w_nextShift  = r_shift >> 1;
            w_nextBitIdx = r_bitIdx + 3'd1;
            w_nextTx     = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_bitDone) begin
          w_nextTimer = '0;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_nextShift = w_head;
            w_nextState = START;
            w_nextTx    = 1'b0;
          end else begin
            w_nextState = IDLE;
            w_nextTx    = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextTx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bitTimer <= '0;
      r_bitIdx   <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_bitTimer <= w_nextTimer;
      r_bitIdx   <= w_nextBitIdx;
      r_shift    <= w_nextShift;
      r_tx       <= w_nextTx;
      r_busy     <= (w_nextState != IDLE) || (w_nextCount != '0);
      r_count    <= w_nextCount;
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_pop)
        r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push)
        r_wrPtr <= r_wrPtr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= bus.result_data;
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_result_uart_tx.sv
// Drives result_uart_tx with directed and random byte strobes and compares every cycle
// against a frame-level model; a serial decoder on tx recovers the transmitted bytes.
module tb_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mq [$];
  bit         mActive   = 1'b0;
  int         mIdx      = 0;
  logic [7:0] mFrame    = 8'h00;
  bit         mOverflow = 1'b0;

  int         rxOff = -1;
  logic [7:0] rxByte;
  logic [7:0] rxq [$];
  int         peakCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A frame is ten bit slots of CPB cycles each: start 0, eight data bits LSB first, stop 1.
  function automatic logic expectedTx();
    int k;
    if (!mActive) return 1'b1;
    k = mIdx / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return mFrame[k-1];
  endfunction

  task automatic modelStep(input bit rst, input bit v, input logic [7:0] d);
    bit frameEnd, pop, push;
    logic [7:0] head;
    if (rst) begin
      mq.delete();
      mActive   = 1'b0;
      mIdx      = 0;
      mOverflow = 1'b0;
      return;
    end
    frameEnd = mActive && (mIdx == FRAME - 1);
    pop      = (mq.size() > 0) && (!mActive || frameEnd);
    push     = v && ((mq.size() < DEPTH) || pop);
    if (v && !push) mOverflow = 1'b1;
    head = 8'h00;
    if (pop) head = mq.pop_front();
    if (push) mq.push_back(d);
    if (pop) begin
      mActive = 1'b1;
      mIdx    = 0;
      mFrame  = head;
    end else if (frameEnd) begin
      mActive = 1'b0;
    end else if (mActive) begin
      mIdx++;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d);
    reset            = rst;
    bus.result_valid = v;
    bus.result_data  = d;
    @(posedge clk);
    modelStep(rst, v, d);
    #1;
    checkOutput("tx", bus.tx, expectedTx());
    checkOutput("busy", bus.busy, (mActive || mq.size() != 0));
    checkOutput("overflow", bus.overflow, mOverflow);
    checkOutput("fifo_count", bus.fifo_count, mq.size());
    if (int'(bus.fifo_count) > peakCount) peakCount = int'(bus.fifo_count);
    if (rst) begin
      rxOff = -1;
    end else if (rxOff < 0) begin
      if (bus.tx == 1'b0) rxOff = 0;
    end else begin
      rxOff++;
      if ((rxOff % CPB == CPB / 2) && (rxOff / CPB >= 1) && (rxOff / CPB <= 8))
        rxByte[rxOff/CPB-1] = bus.tx;
      if (rxOff == 9 * CPB + CPB / 2) begin
        checkOutput("rxStop", bus.tx, 1);
        rxq.push_back(rxByte);
        rxOff = -1;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (bus.busy && guard < 1000) begin
      idleCycles(1);
      guard++;
    end
    checkOutput(tag, bus.busy, 0);
    idleCycles(4);
  endtask

  task automatic checkRx(input string tag, input logic [7:0] exp [$]);
    checkOutput({tag, "Len"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < rxq.size()) checkOutput(tag, rxq[i], exp[i]);
    rxq.delete();
  endtask

  // Counts sampled cycles from the first start-bit cycle until busy drops.
  task automatic measureFrames(input string tag, input int already, input int expected);
    int len = already;
    int guard = 0;
    while (guard < 1000) begin
      idleCycles(1);
      guard++;
      if (!bus.busy) break;
      len++;
    end
    checkOutput(tag, len, expected);
  endtask

  task automatic waitModelIdx(input string tag, input int idx);
    int guard = 0;
    while (!(mActive && mIdx == idx) && guard < 500) begin
      idleCycles(1);
      guard++;
    end
    checkOutput(tag, (mActive && mIdx == idx), 1);
  endtask

  initial begin
    bit rst, v;
    reset            = 1'b1;
    bus.result_valid = 1'b0;
    bus.result_data  = 8'h00;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rstTx", bus.tx, 1);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstOverflow", bus.overflow, 0);
    checkOutput("rstCount", bus.fifo_count, 0);
    idleCycles(100);
    checkOutput("idleTx", bus.tx, 1);

    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkOutput("singleTxAtE", bus.tx, 1);
    idleCycles(1);
    checkOutput("singleTxAtE1", bus.tx, 0);
    measureFrames("singleFrameLen", 1, FRAME);
    idleCycles(4);
    checkRx("singleRx", '{8'hA5});

    peakCount = 0;
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h03);
    measureFrames("b2bLen", 2, 3 * FRAME);
    idleCycles(4);
    checkOutput("b2bPeak", peakCount, 2);
    checkRx("b2bRx", '{8'h01, 8'h02, 8'h03});

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
    checkOutput("ovfSet", bus.overflow, 1);
    drain("ovfDrain");
    checkOutput("ovfSticky", bus.overflow, 1);
    checkRx("ovfRx", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("ovfCleared", bus.overflow, 0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h20 + i));
    checkOutput("fullCount", bus.fifo_count, 4);
    waitModelIdx("collWait", FRAME - 1);
    applyStimulus(1'b0, 1'b1, 8'h25);
    checkOutput("collCount", bus.fifo_count, 4);
    checkOutput("collOverflow", bus.overflow, 0);
    drain("collDrain");
    checkRx("collRx", '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25});

    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    applyStimulus(1'b0, 1'b1, 8'h55);
    waitModelIdx("midWait", 4 * CPB + 1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("midTx", bus.tx, 1);
    checkOutput("midCount", bus.fifo_count, 0);
    checkOutput("midBusy", bus.busy, 0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    drain("midDrain");
    checkRx("midRx", '{8'h3C});

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      v   = ($urandom_range(0, 9) < 2);
      applyStimulus(rst, v, 8'($urandom));
    end
    drain("randDrain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
